// File: rtl/alu_stage_pkg.sv
// Shared definitions for the ALU result stage: op-code width, the highest
// op code the result mux decodes, and the skid-buffer occupancy states.
package alu_stage_pkg;

  localparam int OP_W = 4;

  // Highest op code with a decoded mux input; anything above selects the
  // mux default input.
  localparam logic [OP_W-1:0] OP_MAX = 4'd10;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } occ_t;

  // Op codes beyond OP_MAX make the mux fall through to its default input.
  function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
    return (op > OP_MAX);
  endfunction

  // The result entry {data, op, zero, neg, illegal} depends on the data
  // width N, so it is declared as a packed struct inside alu_result_stage
  // where N is known; the buffer below only sees it as a flat vector.

endpackage

// File: rtl/alu_result_stage_skid_buffer_2.sv
// Generic 2-entry valid/ready skid buffer. Entries are opaque W-bit
// vectors. in_ready depends only on the registered occupancy, so there is
// no combinational path from out_ready back to in_ready.
module skid_buffer_2
  import alu_stage_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_t         state_reg, state_next;
  logic [W-1:0] head_reg, head_next;
  logic [W-1:0] tail_reg, tail_next;
  logic         push, pop;

  assign in_ready  = (state_reg != TWO);
  assign out_valid = (state_reg != EMPTY);
  assign out_data  = head_reg;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Occupancy and entry registers; reset drops every held entry at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      state_reg <= state_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
    end
  end

  // Next occupancy and entry movement; the head is always the oldest entry.
  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    case (state_reg)
      EMPTY: begin
        if (push) begin
          head_next  = in_data;
          state_next = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_next = in_data;
        end else if (push) begin
          tail_next  = in_data;
          state_next = TWO;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only a pop can happen.
        if (pop) begin
          head_next  = tail_reg;
          state_next = ONE;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage behind the 11-input result mux. Drives the mux
// select straight from the incoming op code, tags the returned result with
// zero/negative/illegal flags and queues it in a 2-entry skid buffer.
// Optional feature macro: ALU_RESULT_PARITY_EN adds out_parity and a
// saturating count of popped illegal-op results (parity_err_cnt).
module alu_result_stage
  import alu_stage_pkg::*;
#(
  parameter int N = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_op,
  output logic [OP_W-1:0] mux_sel,
  input  logic [N-1:0]    mux_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_data,
  output logic [OP_W-1:0] out_op,
  output logic            out_zero,
  output logic            out_neg,
  output logic            out_illegal
`ifdef ALU_RESULT_PARITY_EN
  ,
  output logic            out_parity,
  output logic [7:0]      parity_err_cnt
`endif
);

  typedef struct packed {
    logic [N-1:0]    data;
    logic [OP_W-1:0] op;
    logic            zero;
    logic            neg;
    logic            illegal;
`ifdef ALU_RESULT_PARITY_EN
    logic            parity;
`endif
  } result_entry_t;

  result_entry_t cap_entry;
  result_entry_t head_entry;

  // The mux select is a pure wire copy of the op code: zero added latency.
  assign mux_sel = in_op;

  // Flags are derived from the mux result at capture so the head registers
  // feed the outputs directly.
  always_comb begin
    cap_entry.data    = mux_out;
    cap_entry.op      = in_op;
    cap_entry.zero    = (mux_out == '0);
    cap_entry.neg     = mux_out[N-1];
    cap_entry.illegal = op_is_illegal(in_op);
`ifdef ALU_RESULT_PARITY_EN
    cap_entry.parity  = ^mux_out;
`endif
  end

  skid_buffer_2 #(
    .W($bits(result_entry_t))
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (cap_entry),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (head_entry)
  );

  assign out_data    = head_entry.data;
  assign out_op      = head_entry.op;
  assign out_zero    = head_entry.zero;
  assign out_neg     = head_entry.neg;
  assign out_illegal = head_entry.illegal;

`ifdef ALU_RESULT_PARITY_EN
  logic [7:0] err_cnt_reg;

  assign out_parity     = head_entry.parity;
  assign parity_err_cnt = err_cnt_reg;

  // Count results from undecoded ops as they leave, saturating at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg <= 8'd0;
    end else if (out_valid && out_ready && head_entry.illegal && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end
`endif

endmodule
